// File: rtl/axi4_lite_intl_regbank.sv
// AXI4-Lite register bank with a sticky interlock status register at index 0.
// Optional macro INTL_SHADOW_COMMIT_EN: output registers are shadowed and copied to o_reg on a COMMIT write to index N-1.
module axi4_lite_intl_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_NUM   = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter logic [C_S_AXI_ADDR_NUM-1:0] IO_SEL = {C_S_AXI_ADDR_NUM{1'b1}},
  parameter int N_INTL = 16
) (
  input  logic                                       S_AXI_ACLK,
  input  logic                                       S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
  input  logic [2:0]                                 S_AXI_AWPROT,
  input  logic                                       S_AXI_AWVALID,
  output logic                                       S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
  input  logic                                       S_AXI_WVALID,
  output logic                                       S_AXI_WREADY,
  output logic [1:0]                                 S_AXI_BRESP,
  output logic                                       S_AXI_BVALID,
  input  logic                                       S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
  input  logic [2:0]                                 S_AXI_ARPROT,
  input  logic                                       S_AXI_ARVALID,
  output logic                                       S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
  output logic [1:0]                                 S_AXI_RRESP,
  output logic                                       S_AXI_RVALID,
  input  logic                                       S_AXI_RREADY,
  input  logic [C_S_AXI_ADDR_NUM*C_S_AXI_DATA_WIDTH-1:0] i_reg,
  output logic [C_S_AXI_ADDR_NUM*C_S_AXI_DATA_WIDTH-1:0] o_reg,
  input  logic [N_INTL-1:0]                          i_intl,
  output logic                                       o_intl_any
);

  // Only a 32-bit data path is supported.
  localparam int N        = C_S_AXI_ADDR_NUM;
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int ADDR_LSB = 2;
  localparam int IDX_W    = $clog2(N + 1);

`ifdef INTL_SHADOW_COMMIT_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_en, wr_err, wr_hit, rd_en, rd_ok;
  logic [DW-1:0]    strb_mask, wmask, rd_val;
  logic [DW-1:0]    regs [N];
  logic [N_INTL-1:0] sticky, w1c;
  logic             commit_pulse;
  logic             awready, bvalid, arready, rvalid;
  logic             unused_ok;

  assign wr_idx = S_AXI_AWADDR[ADDR_LSB+IDX_W-1:ADDR_LSB];
  assign rd_idx = S_AXI_ARADDR[ADDR_LSB+IDX_W-1:ADDR_LSB];
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  always_comb begin
    wr_en  = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid & ~awready;
    rd_en  = S_AXI_ARVALID & ~arready & ~rvalid;
    wr_err = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (wr_idx == IDX_W'(k))
        wr_err = (k != 0) && !IO_SEL[k] && !(SHADOW && k == N-1);
    end
    wr_hit = wr_en & ~wr_err;
    for (int b = 0; b < DW/8; b++) strb_mask[b*8 +: 8] = {8{S_AXI_WSTRB[b]}};
    wmask = S_AXI_WDATA & strb_mask;
    w1c   = '0;
    if (wr_hit && wr_idx == '0) w1c = wmask[N_INTL-1:0];
    rd_val = '0;
    rd_ok  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (rd_idx == IDX_W'(k)) begin
        rd_ok = 1'b1;
        if (k == 0)                     rd_val[N_INTL-1:0] = sticky;
        else if (!(SHADOW && k == N-1)) rd_val = regs[k];
      end
    end
  end

  // General registers: PS-writable outputs or PL inputs resampled every cycle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int k = 0; k < N; k++) regs[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (k == 0 || (SHADOW && k == N-1))
          regs[k] <= '0;
        else if (!IO_SEL[k])
          regs[k] <= i_reg[k*DW +: DW];
        else if (wr_hit && wr_idx == IDX_W'(k))
          regs[k] <= (regs[k] & ~strb_mask) | wmask;
      end
    end
  end

  // Set has priority over a coincident write-1-to-clear.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sticky       <= '0;
      o_intl_any   <= 1'b0;
      commit_pulse <= 1'b0;
    end else begin
      sticky       <= i_intl | (sticky & ~w1c);
      o_intl_any   <= |sticky;
      commit_pulse <= SHADOW && wr_hit && (wr_idx == IDX_W'(N-1)) &&
                      S_AXI_WSTRB[0] && S_AXI_WDATA[0];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      o_reg <= '0;
    end else if (!SHADOW || commit_pulse) begin
      for (int k = 0; k < N; k++)
        o_reg[k*DW +: DW] <= (k != 0 && IO_SEL[k] && !(SHADOW && k == N-1)) ? regs[k] : '0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready     <= 1'b0;
      bvalid      <= 1'b0;
      S_AXI_BRESP <= 2'b00;
    end else begin
      awready <= wr_en;
      if (wr_en) S_AXI_BRESP <= wr_err ? 2'b10 : 2'b00;
      if (awready)           bvalid <= 1'b1;
      else if (S_AXI_BREADY) bvalid <= 1'b0;
    end
  end

  // Read data is captured at the accept edge, so a same-cycle write is not visible.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready     <= 1'b0;
      rvalid      <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= 2'b00;
    end else begin
      arready <= rd_en;
      if (rd_en) begin
        S_AXI_RDATA <= rd_val;
        S_AXI_RRESP <= rd_ok ? 2'b00 : 2'b10;
      end
      if (arready)           rvalid <= 1'b1;
      else if (S_AXI_RREADY) rvalid <= 1'b0;
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = awready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;

endmodule

// File: tb/tb_axi4_lite_intl_regbank.sv
// Randomized self-checking bench for axi4_lite_intl_regbank against a register-level reference model.
module tb_axi4_lite_intl_regbank;

  localparam int N  = 32;
  localparam int AW = 8;
  localparam int NI = 16;
  localparam logic [N-1:0] IOS = 32'hFFFF_FDDF;  // indices 5 and 9 are PL inputs
`ifdef INTL_SHADOW_COMMIT_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clk, rst_n;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [N*32-1:0] i_reg, o_reg;
  logic [NI-1:0] i_intl;
  logic          o_intl_any;

  int checks = 0;
  int errors = 0;

  logic [31:0]   ireg_val [N];
  logic [31:0]   m_reg [N];
  logic [31:0]   m_out [N];
  logic [NI-1:0] m_sticky;

  axi4_lite_intl_regbank #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_NUM(N), .C_S_AXI_ADDR_WIDTH(AW),
    .IO_SEL(IOS), .N_INTL(NI)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .i_reg(i_reg), .o_reg(o_reg), .i_intl(i_intl), .o_intl_any(o_intl_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [1:0] exp_wresp(input int idx);
    if (idx >= N) return 2'b10;
    if (idx == 0 || (SHADOW && idx == N-1)) return 2'b00;
    return IOS[idx] ? 2'b00 : 2'b10;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin m_reg[k] = '0; m_out[k] = '0; end
    m_sticky = '0;
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    if (exp_wresp(idx) != 2'b00) return;
    m = merge(32'h0, d, s);
    if (idx == 0) m_sticky = m_sticky & ~m[NI-1:0];
    else if (SHADOW && idx == N-1) begin
      if (m[0]) for (int k = 1; k < N-1; k++) if (IOS[k]) m_out[k] = m_reg[k];
    end else begin
      m_reg[idx] = merge(m_reg[idx], d, s);
      if (!SHADOW) m_out[idx] = m_reg[idx];
    end
  endtask

  task automatic model_read(input int idx, output logic [31:0] d, output logic [1:0] r);
    r = 2'b00;
    if (idx >= N) begin d = '0; r = 2'b10; end
    else if (idx == 0) d = {{(32-NI){1'b0}}, m_sticky};
    else if (SHADOW && idx == N-1) d = '0;
    else if (!IOS[idx]) d = ireg_val[idx];
    else d = m_reg[idx];
  endtask

  function automatic logic [N*32-1:0] exp_oreg();
    logic [N*32-1:0] v;
    for (int k = 0; k < N; k++) v[k*32 +: 32] = m_out[k];
    return v;
  endfunction

  // ---------------- bus transactions ----------------
  task automatic axi_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit ok);
    int t;
    ok = 1'b1;
    @(negedge clk);
    awaddr = 8'(idx * 4); wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    t = 0;
    while (!awready && t < 20) begin @(negedge clk); t++; end
    if (!awready) ok = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    while (!bvalid && t < 20) begin @(negedge clk); t++; end
    if (!bvalid) ok = 1'b0;
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input int idx, output logic [31:0] d, output logic [1:0] resp, output bit ok);
    int t;
    ok = 1'b1;
    @(negedge clk);
    araddr = 8'(idx * 4); arvalid = 1'b1; rready = 1'b1;
    t = 0;
    while (!arready && t < 20) begin @(negedge clk); t++; end
    if (!arready) ok = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 20) begin @(negedge clk); t++; end
    if (!rvalid) ok = 1'b0;
    d = rdata; resp = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, o_intl_any} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {awready, wready, bvalid, arready, rvalid, o_intl_any});
    end
    checks++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      errors++; $display("FAIL reset_resp_rdata: got bresp=%b rresp=%b rdata=%h want 0", bresp, rresp, rdata);
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (o_reg !== exp_oreg()) begin
      errors++; $display("FAIL reset_oreg: got %h want %h", o_reg, exp_oreg());
    end
  endtask

  task automatic test_spec_vector();
    logic [1:0] r; logic [31:0] d; bit ok;
    axi_write(3, 32'hDEADBEEF, 4'b0101, r, ok);
    model_write(3, 32'hDEADBEEF, 4'b0101);
    checks++;
    if (!ok || r !== 2'b00) begin errors++; $display("FAIL vec_bresp: got %b ok=%0d want 00", r, ok); end
    checks++;
    if (o_reg !== exp_oreg()) begin
      errors++; $display("FAIL vec_oreg: got slice3=%h want %h", o_reg[3*32 +: 32], m_out[3]);
    end
    axi_read(3, d, r, ok);
    checks++;
    if (!ok || d !== 32'h00AD00EF || r !== 2'b00) begin
      errors++; $display("FAIL vec_readback: got %h/%b want 00ad00ef/00", d, r);
    end
  endtask

  task automatic test_intl();
    logic [1:0] r; logic [31:0] d, e; bit ok;
    @(negedge clk); i_intl = 16'h0004;
    @(negedge clk); i_intl = '0;
    m_sticky = m_sticky | 16'h0004;
    checks++;
    if (o_intl_any !== 1'b0) begin errors++; $display("FAIL intl_any_latency: got %b want 0", o_intl_any); end
    @(negedge clk);
    checks++;
    if (o_intl_any !== 1'b1) begin errors++; $display("FAIL intl_any_set: got %b want 1", o_intl_any); end
    axi_read(0, d, r, ok);
    checks++;
    if (!ok || d !== 32'h4 || r !== 2'b00) begin errors++; $display("FAIL intl_status: got %h want 00000004", d); end
    axi_write(0, 32'h4, 4'hF, r, ok);
    model_write(0, 32'h4, 4'hF);
    axi_read(0, d, r, ok);
    model_read(0, e, r);
    checks++;
    if (!ok || d !== e) begin errors++; $display("FAIL intl_w1c: got %h want %h", d, e); end
    @(negedge clk);
    checks++;
    if (o_intl_any !== 1'b0) begin errors++; $display("FAIL intl_any_clear: got %b want 0", o_intl_any); end
    @(negedge clk); i_intl = 16'h0004;
    axi_write(0, 32'h4, 4'hF, r, ok);
    i_intl = '0;
    m_sticky = m_sticky | 16'h0004;
    axi_read(0, d, r, ok);
    checks++;
    if (!ok || d !== 32'h4) begin errors++; $display("FAIL intl_set_wins: got %h want 00000004", d); end
    checks++;
    if (o_intl_any !== 1'b1) begin errors++; $display("FAIL intl_any_hold: got %b want 1", o_intl_any); end
  endtask

  task automatic test_errors();
    logic [1:0] r, er; logic [31:0] d, e; bit ok;
    axi_write(N, $urandom, 4'hF, r, ok);
    checks++;
    if (!ok || r !== 2'b10) begin errors++; $display("FAIL err_oob_bresp: got %b want 10", r); end
    axi_write(5, $urandom, 4'hF, r, ok);
    checks++;
    if (!ok || r !== 2'b10) begin errors++; $display("FAIL err_input_bresp: got %b want 10", r); end
    axi_write(7, $urandom, 4'h0, r, ok);
    checks++;
    if (!ok || r !== 2'b00) begin errors++; $display("FAIL err_strb0_bresp: got %b want 00", r); end
    checks++;
    if (o_reg !== exp_oreg()) begin errors++; $display("FAIL err_oreg_changed: got %h want %h", o_reg, exp_oreg()); end
    foreach (ireg_val[i]) begin end
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (i == 0) ? N : (i == 1) ? 63 : (i == 2) ? 5 : 7;
      axi_read(idx, d, r, ok);
      model_read(idx, e, er);
      checks++;
      if (!ok || d !== e || r !== er) begin
        errors++; $display("FAIL err_read idx=%0d: got %h/%b want %h/%b", idx, d, r, e, er);
      end
    end
  endtask

  task automatic test_half_channel();
    int seen; logic [31:0] d, e; logic [1:0] r; bit ok;
    seen = 0;
    @(negedge clk); awaddr = 8'(4 * 4); awvalid = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    repeat (6) begin @(negedge clk); if (awready || wready) seen++; end
    awvalid = 1'b0; wvalid = 1'b1;
    repeat (6) begin @(negedge clk); if (awready || wready) seen++; end
    wvalid = 1'b0;
    checks++;
    if (seen != 0) begin errors++; $display("FAIL half_channel_accept: got %0d accepts want 0", seen); end
    axi_read(4, d, r, ok);
    model_read(4, e, r);
    checks++;
    if (!ok || d !== e) begin errors++; $display("FAIL half_channel_state: got %h want %h", d, e); end
  endtask

  task automatic test_random();
    logic [1:0] r, er; logic [31:0] d, e, wd; logic [3:0] s; bit ok; logic [NI-1:0] p;
    p = NI'($urandom);
    @(negedge clk); i_intl = p;
    @(negedge clk); i_intl = '0;
    m_sticky = m_sticky | p;
    for (int it = 0; it < 60; it++) begin
      int wi, ri;
      wi = ($urandom_range(0, 15) == 0) ? 63 : $urandom_range(0, N + 2);
      ri = $urandom_range(0, N + 2);
      wd = $urandom; s = 4'($urandom_range(0, 15));
      axi_write(wi, wd, s, r, ok);
      checks++;
      if (!ok || r !== exp_wresp(wi)) begin
        errors++; $display("FAIL rnd_bresp idx=%0d: got %b want %b", wi, r, exp_wresp(wi));
      end
      model_write(wi, wd, s);
      checks++;
      if (o_reg !== exp_oreg()) begin errors++; $display("FAIL rnd_oreg after idx=%0d", wi); end
      axi_read(ri, d, r, ok);
      model_read(ri, e, er);
      checks++;
      if (!ok || d !== e || r !== er) begin
        errors++; $display("FAIL rnd_read idx=%0d: got %h/%b want %h/%b", ri, d, r, e, er);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t, bad_b, bad_acc, bad_r; logic [31:0] d1, d2, hold, d, e; logic [1:0] r; bit ok;
    d1 = $urandom; d2 = ~d1;
    @(negedge clk);
    awaddr = 8'(10 * 4); wdata = d1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    t = 0;
    while (!awready && t < 20) begin @(negedge clk); t++; end
    wdata = d2;
    bad_b = 0; bad_acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bvalid !== 1'b1) bad_b++;
      if (awready !== 1'b0) bad_acc++;
    end
    model_write(10, d1, 4'hF);
    checks++;
    if (bad_b != 0) begin errors++; $display("FAIL bp_bvalid_hold: %0d cycles low want 0", bad_b); end
    checks++;
    if (bad_acc != 0) begin errors++; $display("FAIL bp_second_write: %0d accepts want 0", bad_acc); end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL bp_b_release: got %b want 0", bvalid); end
    bready = 1'b0;
    @(negedge clk);
    araddr = 8'(10 * 4); arvalid = 1'b1; rready = 1'b0;
    t = 0;
    while (!arready && t < 20) begin @(negedge clk); t++; end
    araddr = '0;
    model_read(10, e, r);
    bad_r = 0; bad_acc = 0; hold = 'x;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rvalid !== 1'b1 || rdata !== e) bad_r++;
      if (arready !== 1'b0) bad_acc++;
      hold = rdata;
    end
    checks++;
    if (bad_r != 0) begin errors++; $display("FAIL bp_rdata_hold: got %h want %h (%0d bad)", hold, e, bad_r); end
    checks++;
    if (bad_acc != 0) begin errors++; $display("FAIL bp_second_read: %0d accepts want 0", bad_acc); end
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL bp_r_release: got %b want 0", rvalid); end
    rready = 1'b0;
    axi_read(10, d, r, ok);
    checks++;
    if (!ok || d !== e) begin errors++; $display("FAIL bp_final_value: got %h want %h", d, e); end
  endtask

  task automatic test_simultaneous();
    logic [1:0] r, br, rr; logic [31:0] old_v, new_v, d, rd; bit ok, aw_drop, ar_drop, got_b, got_r;
    axi_write(12, $urandom, 4'hF, r, ok);
    model_write(12, wdata, 4'hF);
    model_read(12, old_v, r);
    new_v = ~old_v;
    @(negedge clk);
    awaddr = 8'(12 * 4); wdata = new_v; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'(12 * 4); arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    aw_drop = 0; ar_drop = 0; got_b = 0; got_r = 0; rd = 'x; br = 'x; rr = 'x;
    for (int i = 0; i < 30 && !(got_b && got_r); i++) begin
      @(negedge clk);
      if (aw_drop) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (ar_drop) arvalid = 1'b0;
      if (awvalid && awready) aw_drop = 1;
      if (arvalid && arready) ar_drop = 1;
      if (bvalid && !got_b) begin got_b = 1; br = bresp; end
      if (rvalid && !got_r) begin got_r = 1; rd = rdata; rr = rresp; end
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    model_write(12, new_v, 4'hF);
    checks++;
    if (!got_b || br !== 2'b00) begin errors++; $display("FAIL sim_bresp: got %b done=%0d want 00", br, got_b); end
    checks++;
    if (!got_r || rd !== old_v || rr !== 2'b00) begin
      errors++; $display("FAIL sim_read_old: got %h want %h", rd, old_v);
    end
    axi_read(12, d, r, ok);
    checks++;
    if (!ok || d !== new_v) begin errors++; $display("FAIL sim_read_new: got %h want %h", d, new_v); end
  endtask

  task automatic test_reset_mid();
    int t, stale; logic [31:0] d, e; logic [1:0] r; bit ok;
    @(negedge clk);
    awaddr = 8'(3 * 4); wdata = $urandom; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    t = 0;
    while (!bvalid && t < 20) begin @(negedge clk); t++; end
    awvalid = 1'b0; wvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b0) begin
      errors++; $display("FAIL rstmid_async_flags: bvalid=%b awready=%b want 0", bvalid, awready);
    end
    checks++;
    if (o_reg !== '0 || o_intl_any !== 1'b0) begin
      errors++; $display("FAIL rstmid_async_oreg: o_reg nonzero or o_intl_any=%b", o_intl_any);
    end
    @(negedge clk);
    rst_n = 1'b1; bready = 1'b1;
    model_reset();
    stale = 0;
    repeat (5) begin @(negedge clk); if (bvalid) stale++; end
    bready = 1'b0;
    checks++;
    if (stale != 0) begin errors++; $display("FAIL rstmid_stale_b: %0d cycles bvalid want 0", stale); end
    axi_read(3, d, r, ok);
    model_read(3, e, r);
    checks++;
    if (!ok || d !== e) begin errors++; $display("FAIL rstmid_reg_cleared: got %h want %h", d, e); end
  endtask

`ifdef INTL_SHADOW_COMMIT_EN
  task automatic test_shadow();
    logic [1:0] r; logic [31:0] d, before; bit ok;
    before = o_reg[1*32 +: 32];
    axi_write(1, 32'h55, 4'hF, r, ok);
    model_write(1, 32'h55, 4'hF);
    checks++;
    if (o_reg[1*32 +: 32] !== before) begin errors++; $display("FAIL shadow_no_update: got %h want %h", o_reg[1*32 +: 32], before); end
    axi_write(N-1, 32'h1, 4'hF, r, ok);
    model_write(N-1, 32'h1, 4'hF);
    checks++;
    if (o_reg[1*32 +: 32] !== 32'h55) begin errors++; $display("FAIL shadow_commit: got %h want 00000055", o_reg[1*32 +: 32]); end
    axi_read(N-1, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0) begin errors++; $display("FAIL shadow_commit_reads0: got %h want 0", d); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0; i_intl = '0;
    for (int k = 0; k < N; k++) begin
      ireg_val[k] = $urandom;
      i_reg[k*32 +: 32] = ireg_val[k];
    end
    model_reset();
    test_reset();
    test_spec_vector();
    test_intl();
    test_errors();
    test_half_channel();
    test_back_to_back();
    test_simultaneous();
    test_random();
`ifdef INTL_SHADOW_COMMIT_EN
    test_shadow();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
